// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the machine word, the fetch FSM states and the HALT encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Fetch stage states: requesting from icache, holding a stalled word, stopped on HALT
    typedef enum logic [1:0] {
        REQ    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

    // PC advance; 32-bit modulo, so 32'hFFFF_FFFC wraps to 0
    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_holdreg.sv
// Holds one fetched {instr, pc_4} pair while the IF/ID register is stalled.
// clear takes priority over load.
module fetch_holdreg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  logic  clear,
    input  word_t instr_in,
    input  word_t pc_4_in,
    output word_t instr,
    output word_t pc_4
);

    // Buffer register: async reset, clear wins over load
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr <= '0;
            pc_4  <= '0;
        end else if (clear) begin
            instr <= '0;
            pc_4  <= '0;
        end else if (load) begin
            instr <= instr_in;
            pc_4  <= pc_4_in;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from the icache and
// delivers {instr, pc+4} with valid_out into IF/ID. Optional performance
// counters are built when FETCH_PERFCNT_EN is defined.
//
// Handshake: a word transfers into IF/ID on any cycle where valid_out=1 and
// stall=0; while stall=1 with valid_out=1 the outputs are held stable.
// redirect overrides everything and suppresses valid_out for that cycle.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_RESET  = 32'h0000_0000,
    parameter word_t HALT_WORD = HALT_INSTR
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         ihit,
    input  word_t        iload,
    output logic         iREN,
    output word_t        iaddr,
    input  logic         stall,
    input  logic         redirect,
    input  word_t        redirect_addr,
    output word_t        instr_out,
    output word_t        pc_4_out,
    output logic         valid_out,
    output logic         halted,
`ifdef FETCH_PERFCNT_EN
    output logic [31:0]  fetch_count,
    output logic [31:0]  stall_count,
`endif
    output fetch_state_t state_dbg
);

    fetch_state_t state, state_n;
    word_t        pc, pc_n;
    word_t        hold_instr, hold_pc_4;
    logic         hold_load, hold_clear;
    logic         iren_c, valid_c, halted_c;
    word_t        instr_c, pc_4_c;

    fetch_holdreg u_holdreg (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (hold_load),
        .clear    (hold_clear),
        .instr_in (iload),
        .pc_4_in  (pc_plus4(pc)),
        .instr    (hold_instr),
        .pc_4     (hold_pc_4)
    );

    // State and PC registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= REQ;
            pc    <= PC_RESET;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    // Next-state, PC update and stage outputs; redirect overrides at the end
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        iren_c     = 1'b0;
        valid_c    = 1'b0;
        halted_c   = 1'b0;
        instr_c    = '0;
        pc_4_c     = '0;
        case (state)
            REQ: begin
                iren_c = 1'b1;
                if (ihit && !redirect) begin
                    valid_c = 1'b1;
                    instr_c = iload;
                    pc_4_c  = pc_plus4(pc);
                    if (!stall) begin
                        pc_n = pc_plus4(pc);
                        if (iload == HALT_WORD) state_n = HALTED;
                    end else begin
                        hold_load = 1'b1;
                        state_n   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!redirect) begin
                    valid_c = 1'b1;
                    instr_c = hold_instr;
                    pc_4_c  = hold_pc_4;
                    if (!stall) begin
                        pc_n    = pc_plus4(pc);
                        state_n = (hold_instr == HALT_WORD) ? HALTED : REQ;
                    end
                end
            end
            HALTED: begin
                halted_c = 1'b1;
            end
            default: begin
                state_n = REQ;
            end
        endcase
        if (redirect) begin
            pc_n       = redirect_addr;
            state_n    = REQ;
            hold_load  = 1'b0;
            hold_clear = 1'b1;
        end
    end

    // Outputs are forced low while reset is held, including the icache request
    assign iREN      = iren_c & nRST;
    assign valid_out = valid_c & nRST;
    assign iaddr     = pc;
    assign instr_out = valid_out ? instr_c : '0;
    assign pc_4_out  = valid_out ? pc_4_c  : '0;
    assign halted    = halted_c;
    assign state_dbg = state;

`ifdef FETCH_PERFCNT_EN
    // Transfer and stall counters; both stop moving once fetch is halted
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (valid_out && !stall) fetch_count <= fetch_count + 32'd1;
            if (state == HOLD)       stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transfers are checked by a scoreboard
// monitor against an expected queue; control outputs are checked inline.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic         CLK;
  logic         nRST;
  logic         ihit;
  word_t        iload;
  logic         iREN;
  word_t        iaddr;
  logic         stall;
  logic         redirect;
  word_t        redirect_addr;
  word_t        instr_out;
  word_t        pc_4_out;
  logic         valid_out;
  logic         halted;
  fetch_state_t state_dbg;
`ifdef FETCH_PERFCNT_EN
  logic [31:0]  fetch_count;
  logic [31:0]  stall_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  fetch_unit dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ihit          (ihit),
    .iload         (iload),
    .iREN          (iREN),
    .iaddr         (iaddr),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr_out     (instr_out),
    .pc_4_out      (pc_4_out),
    .valid_out     (valid_out),
    .halted        (halted),
`ifdef FETCH_PERFCNT_EN
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
`endif
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic ih, input word_t ld, input logic st,
                       input logic rd, input word_t ra);
    ihit = ih; iload = ld; stall = st; redirect = rd; redirect_addr = ra;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // scoreboard monitor: every accepted transfer must match the queue head
  always @(negedge CLK) begin
    if (nRST && valid_out && !stall) begin
      if (exp_q.size() == 0) begin
        check("unexpected_transfer", {instr_out, pc_4_out}, 64'h0);
        if ({instr_out, pc_4_out} == 64'h0) begin
          n_fail++;
          $display("FAIL unexpected_transfer: got %h expected none", {instr_out, pc_4_out});
        end
      end else begin
        check("transfer", {instr_out, pc_4_out}, exp_q.pop_front());
      end
    end
  end

  initial begin
    nRST = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_iREN",   iREN, 0);
    check("rst_iaddr",  iaddr, 0);
    check("rst_valid",  valid_out, 0);
    check("rst_halted", halted, 0);
    check("rst_instr",  instr_out, 0);
    step();
    nRST = 1'b1;

    // straight-line fetch: 0,4,8
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0000_1000 + k, 1'b0, 1'b0, '0);
      exp_q.push_back({32'h0000_1000 + k, 32'(4 * k + 4)});
      @(negedge CLK);
      check("seq_iaddr", iaddr, 64'(4 * k));
      check("seq_iREN",  iREN, 1);
      check("seq_valid", valid_out, 1);
      step();
    end

    // stall on capture, then hold for two more stalled cycles
    drive(1'b1, 32'h2002_0005, 1'b1, 1'b0, '0);
    @(negedge CLK);
    check("cap_iaddr", iaddr, 32'd12);
    check("cap_valid", valid_out, 1);
    step();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
      @(negedge CLK);
      check("hold_iREN",  iREN, 0);
      check("hold_valid", valid_out, 1);
      check("hold_instr", instr_out, 32'h2002_0005);
      check("hold_pc4",   pc_4_out, 32'd16);
      step();
    end
    drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
    exp_q.push_back({32'h2002_0005, 32'd16});
    @(negedge CLK);
    check("hold_rel_iREN", iREN, 0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    @(negedge CLK);
    check("post_hold_iaddr", iaddr, 32'd16);
    check("post_hold_iREN",  iREN, 1);

    // redirect coincident with ihit
    drive(1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 32'h0000_0040);
    @(negedge CLK);
    check("redir_valid", valid_out, 0);
    step();
    drive(1'b1, 32'h0000_00A0, 1'b0, 1'b0, '0);
    exp_q.push_back({32'h0000_00A0, 32'h44});
    @(negedge CLK);
    check("redir_iaddr", iaddr, 32'h40);
    step();

    // redirect during HOLD: buffered word must never be delivered
    drive(1'b1, 32'hBAD0_0002, 1'b1, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b1, 1'b1, 32'h0000_0080);
    @(negedge CLK);
    check("holdredir_valid", valid_out, 0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    @(negedge CLK);
    check("holdredir_iaddr", iaddr, 32'h80);
    check("holdredir_iREN",  iREN, 1);
    check("holdredir_valid2", valid_out, 0);
    step();
    drive(1'b1, 32'h0000_00C0, 1'b0, 1'b0, '0);
    exp_q.push_back({32'h0000_00C0, 32'h84});
    step();

    // HALT delivered, then redirect resumes fetch
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    exp_q.push_back({32'hFFFF_FFFF, 32'h88});
    step();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'hBAD0_0003, 1'b0, 1'b0, '0);
      @(negedge CLK);
      check("halt_halted", halted, 1);
      check("halt_iREN",   iREN, 0);
      check("halt_valid",  valid_out, 0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b1, 32'h0000_0100);
    step();
    drive(1'b1, 32'h0000_0D00, 1'b0, 1'b0, '0);
    exp_q.push_back({32'h0000_0D00, 32'h104});
    @(negedge CLK);
    check("resume_halted", halted, 0);
    check("resume_iREN",   iREN, 1);
    check("resume_iaddr",  iaddr, 32'h100);
    step();

    // PC wrap at the top of the address space
    drive(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b1, 32'h0000_0E00, 1'b0, 1'b0, '0);
    exp_q.push_back({32'h0000_0E00, 32'h0});
    @(negedge CLK);
    check("wrap_iaddr", iaddr, 32'hFFFF_FFFC);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    @(negedge CLK);
    check("wrap_next_iaddr", iaddr, 32'h0);
    step();

    // async reset while holding a stalled word
    drive(1'b1, 32'h0000_0F00, 1'b1, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    @(negedge CLK);
    check("pre_rst_valid", valid_out, 1);
    #2;
    nRST = 1'b0;
    #1;
    check("arst_valid", valid_out, 0);
    check("arst_iREN",  iREN, 0);
    check("arst_instr", instr_out, 0);
    check("arst_pc4",   pc_4_out, 0);
    check("arst_iaddr", iaddr, 0);
    step();
    nRST = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    @(negedge CLK);
    check("rel_iaddr", iaddr, 0);
    check("rel_iREN",  iREN, 1);
    check("rel_valid", valid_out, 0);
`ifdef FETCH_PERFCNT_EN
    check("rel_fetch_count", fetch_count, 0);
    check("rel_stall_count", stall_count, 0);
`endif
    step();

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
